// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the two-port async SRAM arbiter.
// FSM states, grant ids and wait-counter width.
package sram_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WR_SETUP,
    S_WR_PULSE,
    S_DONE
  } state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

endpackage

// File: rtl/sram_arbiter.sv
// IF/MEM arbiter and strobe sequencer for one async SRAM.
// Registered strobes, alternating priority on contention.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_en_n
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(WAIT_CYCLES);

  state_e            state_q;
  gnt_e              gnt_q;
  gnt_e              last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              if_ack_q;
  logic              mem_ack_q;
  logic              oe_n_q;
  logic              we_n_q;
  logic              en_n_q;
  logic              drive_q;

  logic pick_mem;
  logic pick_wr;

  // MEM wins contention unless it won the previous grant.
  assign pick_mem = mem_req &
    (~if_req | (last_q != GNT_MEM));
  assign pick_wr  = pick_mem & mem_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= GNT_IF;
      last_q      <= GNT_IF;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      en_n_q      <= 1'b1;
      drive_q     <= 1'b0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (if_req | mem_req) begin
            gnt_q   <= pick_mem ? GNT_MEM : GNT_IF;
            last_q  <= pick_mem ? GNT_MEM : GNT_IF;
            addr_q  <= pick_mem ? mem_addr : if_addr;
            wdata_q <= mem_wdata;
            cnt_q   <= CNT_INIT;
            en_n_q  <= 1'b0;
            if (pick_wr) begin
              drive_q <= 1'b1;
              state_q <= S_WR_SETUP;
            end else begin
              oe_n_q  <= 1'b0;
              state_q <= S_READ;
            end
          end
        end
        S_READ: begin
          if (cnt_q == '0) begin
            if (gnt_q == GNT_MEM) begin
              mem_rdata_q <= sram_data;
              mem_ack_q   <= 1'b1;
            end else begin
              if_rdata_q <= sram_data;
              if_ack_q   <= 1'b1;
            end
            oe_n_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WR_SETUP: begin
          we_n_q  <= 1'b0;
          state_q <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          if (cnt_q == '0) begin
            we_n_q    <= 1'b1;
            mem_ack_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          // Data stays driven here for write hold time.
          en_n_q  <= 1'b1;
          drive_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sram_data = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign sram_addr = addr_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_en_n = en_n_q;

  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign mem_stall = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed + random bench for sram_arbiter with an async SRAM model.
// Scoreboard queue holds expected port/data per access.
module tb_sram_arbiter;

  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int W   = 2;
  localparam int TMO = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          if_stall;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          mem_stall;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_data;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic          sram_en_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            is_mem;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] last_if_rd  = '0;
  logic [DW-1:0] last_mem_rd = '0;
  logic [DW-1:0] smem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  sram_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .WAIT_CYCLES(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_ack(if_ack),
    .if_stall(if_stall),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .mem_stall(mem_stall),
    .sram_addr(sram_addr),
    .sram_data(sram_data),
    .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n),
    .sram_en_n(sram_en_n)
  );

  assign sram_data = (!sram_en_n && !sram_oe_n) ?
    smem[sram_addr] : {DW{1'bz}};

  always @(posedge sram_we_n)
    if (!sram_en_n) smem[sram_addr] <= sram_data;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("bus_oe_we_low", 32'(sram_oe_n | sram_we_n), 32'd1);
    chk("ack_excl", 32'(if_ack & mem_ack), 32'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit            is_mem,
                        input bit            we,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d,
                        input bit            perturb);
    exp_t e;
    int   n;
    int   wel;
    bit   got;
    e.is_mem = is_mem;
    if (we) begin
      ref_mem[int'(a)] = d;
      e.data = last_mem_rd;
    end else begin
      e.data = ref_mem[int'(a)];
    end
    sbq.push_back(e);
    if (is_mem) begin
      mem_req = 1'b1;
      mem_we = we;
      mem_addr = a;
      mem_wdata = d;
    end else begin
      if_req = 1'b1;
      if_addr = a;
    end
    #1;
    chk("stall_req", 32'(is_mem ? mem_stall : if_stall), 32'd1);
    n = 0;
    wel = 0;
    got = 1'b0;
    while (n < TMO) begin
      if (!sram_we_n) wel++;
      tick();
      n++;
      if (perturb && n == 2) begin
        mem_addr = a ^ 18'd1;
        mem_wdata = ~d;
      end
      got = is_mem ? mem_ack : if_ack;
      if (got) break;
    end
    chk("ack_seen", 32'(got), 32'd1);
    if (got) begin
      e = sbq.pop_front();
      chk("latency", 32'(n), 32'(we ? W + 3 : W + 2));
      chk("we_pulse", 32'(wel), 32'(we ? W + 1 : 0));
      chk("stall_ack", 32'(is_mem ? mem_stall : if_stall), 32'd0);
      chk("rdata", 32'(is_mem ? mem_rdata : if_rdata), 32'(e.data));
      if (!we) begin
        if (is_mem) last_mem_rd = e.data;
        else last_if_rd = e.data;
      end
    end else begin
      sbq.delete();
    end
    if_req = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    tick();
  endtask

  initial begin : main
    exp_t e;
    int   acks;
    int   n;
    tick();
    tick();
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_en_n", 32'(sram_en_n), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_if_rdata", 32'(if_rdata), 32'd0);
    chk("rst_mem_rdata", 32'(mem_rdata), 32'd0);
    chk("rst_acks", 32'({if_ack, mem_ack}), 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 32; i++) begin
      if (i == 16) access(1'b1, 1'b1, AW'(i), 16'h1234, 1'b0);
      else access(1'b1, 1'b1, AW'(i), DW'(i * 16'h0111 + 7), 1'b0);
    end
    chk("wr_no_rdata_change", 32'(mem_rdata), 32'd0);

    access(1'b0, 1'b0, 18'h00010, '0, 1'b0);
    chk("if_rd_1234", 32'(if_rdata), 32'h1234);

    access(1'b1, 1'b1, 18'h3FFFF, 16'hBEEF, 1'b0);
    chk("model_beef", 32'(smem[18'h3FFFF]), 32'hBEEF);
    access(1'b1, 1'b0, 18'h3FFFF, '0, 1'b0);
    chk("mem_rd_beef", 32'(mem_rdata), 32'hBEEF);
    access(1'b0, 1'b0, 18'h3FFFF, '0, 1'b0);
    access(1'b1, 1'b1, 18'h00005, 16'hC0DE, 1'b0);
    chk("mem_rdata_hold", 32'(mem_rdata), 32'hBEEF);

    access(1'b1, 1'b1, 18'h00020, 16'h5A5A, 1'b1);
    chk("latched_data", 32'(smem[18'h00020]), 32'h5A5A);
    chk("latched_addr", 32'(smem[18'h00021]),
        32'(ref_mem[32'h21]));
    access(1'b1, 1'b0, 18'h00020, '0, 1'b0);

    access(1'b0, 1'b0, 18'h00003, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      e.is_mem = (k % 2 == 0);
      e.data = e.is_mem ? ref_mem[32'h20] : ref_mem[32'h10];
      sbq.push_back(e);
    end
    if_req = 1'b1;
    if_addr = 18'h00010;
    mem_req = 1'b1;
    mem_we = 1'b0;
    mem_addr = 18'h00020;
    acks = 0;
    n = 0;
    while (acks < 4 && n < 4 * TMO) begin
      tick();
      n++;
      if (if_ack | mem_ack) begin
        e = sbq.pop_front();
        chk("grant_order", 32'(mem_ack), 32'(e.is_mem));
        chk("both_rdata", 32'(mem_ack ? mem_rdata : if_rdata),
            32'(e.data));
        acks++;
      end
    end
    chk("both_acks", 32'(acks), 32'd4);
    sbq.delete();
    if_req = 1'b0;
    mem_req = 1'b0;
    tick();
    tick();

    if_req = 1'b1;
    if_addr = 18'h00010;
    tick();
    tick();
    tick();
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("mid_rst_en_n", 32'(sram_en_n), 32'd1);
    chk("mid_rst_ack", 32'(if_ack), 32'd0);
    chk("mid_rst_addr", 32'(sram_addr), 32'd0);
    chk("mid_rst_rdata", 32'(if_rdata), 32'd0);
    tick();
    if_req = 1'b0;
    rst = 1'b1;
    last_if_rd = '0;
    last_mem_rd = '0;
    tick();
    tick();
    chk("post_rst_en_n", 32'(sram_en_n), 32'd1);
    chk("post_rst_ack", 32'(if_ack | mem_ack), 32'd0);

    for (int i = 0; i < 1000; i++) begin
      bit            pm;
      bit            pw;
      logic [AW-1:0] ra;
      pm = bit'($urandom_range(0, 1));
      pw = pm & bit'($urandom_range(0, 1));
      ra = AW'($urandom_range(0, 31));
      access(pm, pw, ra, DW'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
